// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the Y86-64 register file: buffers one E and one M
// writeback and issues them one per cycle in acceptance order.
module regfile_wb_arbiter #(
    parameter int W     = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    input  logic [3:0]       e_dst,
    input  logic [W-1:0]     e_data,
    output logic             e_ready,
    input  logic             m_valid,
    input  logic [3:0]       m_dst,
    input  logic [W-1:0]     m_data,
    output logic             m_ready,
    output logic             wr_en,
    output logic [3:0]       wr_addr,
    output logic [W-1:0]     wr_data,
    output logic [14:0]      pend_mask,
    output logic [CNT_W-1:0] wb_count
);

    localparam logic [3:0] RNONE = 4'hF;

    logic             e_hv_q, e_hv_d;
    logic [3:0]       e_dst_q, e_dst_d;
    logic [W-1:0]     e_data_q, e_data_d;
    logic             m_hv_q, m_hv_d;
    logic [3:0]       m_dst_q, m_dst_d;
    logic [W-1:0]     m_data_q, m_data_d;
    logic             m_older_q, m_older_d;
    logic [CNT_W-1:0] wb_count_q, wb_count_d;

    logic sel_e, sel_m, e_acc, m_acc;

    always_comb begin
        // With equal age (m_older=0) E goes first, so popq %rsp leaves valM.
        sel_m = m_hv_q & (~e_hv_q | m_older_q);
        sel_e = e_hv_q & ~sel_m;

        e_ready = ~e_hv_q | sel_e;
        m_ready = ~m_hv_q | sel_m;

        e_acc = e_valid & e_ready & (e_dst != RNONE);
        m_acc = m_valid & m_ready & (m_dst != RNONE);

        wr_en   = sel_e | sel_m;
        wr_addr = '0;
        wr_data = '0;
        if (sel_e) begin
            wr_addr = e_dst_q;
            wr_data = e_data_q;
        end else if (sel_m) begin
            wr_addr = m_dst_q;
            wr_data = m_data_q;
        end
    end

    always_comb begin
        e_hv_d   = e_hv_q & ~sel_e;
        e_dst_d  = e_dst_q;
        e_data_d = e_data_q;
        if (e_acc) begin
            e_hv_d   = 1'b1;
            e_dst_d  = e_dst;
            e_data_d = e_data;
        end

        m_hv_d   = m_hv_q & ~sel_m;
        m_dst_d  = m_dst_q;
        m_data_d = m_data_q;
        if (m_acc) begin
            m_hv_d   = 1'b1;
            m_dst_d  = m_dst;
            m_data_d = m_data;
        end

        // The loading slot is younger than a slot that keeps holding.
        if (e_acc && m_acc) begin
            m_older_d = 1'b0;
        end else if (e_acc) begin
            m_older_d = m_hv_q & ~sel_m;
        end else if (m_acc) begin
            m_older_d = 1'b0;
        end else begin
            m_older_d = m_older_q;
        end

        wb_count_d = wb_count_q + (wr_en ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_hv_q     <= 1'b0;
            e_dst_q    <= '0;
            e_data_q   <= '0;
            m_hv_q     <= 1'b0;
            m_dst_q    <= '0;
            m_data_q   <= '0;
            m_older_q  <= 1'b0;
            wb_count_q <= '0;
        end else begin
            e_hv_q     <= e_hv_d;
            e_dst_q    <= e_dst_d;
            e_data_q   <= e_data_d;
            m_hv_q     <= m_hv_d;
            m_dst_q    <= m_dst_d;
            m_data_q   <= m_data_d;
            m_older_q  <= m_older_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count = wb_count_q;

    generate
        for (genvar gi = 0; gi < 15; gi++) begin : g_pend
            assign pend_mask[gi] = (e_hv_q && (e_dst_q == 4'(gi))) ||
                                   (m_hv_q && (m_dst_q == 4'(gi)));
        end
    endgenerate

endmodule
